// File: rtl/display_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
package display_pkg;
  typedef logic [3:0] digit_code_t;

  localparam int          N_DIGITS   = 4;
  localparam digit_code_t CODE_MINUS = 4'd10;
  localparam digit_code_t CODE_ERR   = 4'd15;
  localparam logic [3:0]  ANODE_OFF  = 4'b1111;

  // Active-low one-cold enable for the selected digit.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// Free-running slot timer: counts 0..REFRESH_DIV-1 and flags the last count as a tick.
module refresh_prescaler #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int            CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CW'(1);
  end
endmodule

// File: rtl/display_scanner.sv
// Four-digit scanner with a one-deep load buffer committed only at frame wrap.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        neg_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank,
  output digit_code_t digit_code,
  output logic [3:0]  anode,
  output logic        frame_start
);
  logic        tick;
  logic [1:0]  idx;
  logic        pending;
  logic [15:0] pend_bcd;
  logic        pend_neg;
  logic [15:0] disp_bcd;
  logic        disp_neg;
  logic        shown;
  logic [1:0]  shown_idx;
  logic [3:0]  lz;
  logic [3:0]  nib;
  digit_code_t code_nxt;
  logic [3:0]  anode_nxt;
  logic        commit;

  refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign load_ready = !pending;
  assign commit     = tick && (idx == 2'd3) && pending;

`ifdef LEADING_ZERO_BLANK_EN
  // A minus sign occupies digit 3, so only 2..1 are candidates when negative.
  logic upper_clear;
  always_comb begin
    lz          = '0;
    upper_clear = disp_neg || (disp_bcd[15:12] == 4'd0);
    lz[3]       = !disp_neg && (disp_bcd[15:12] == 4'd0);
    lz[2]       = upper_clear && (disp_bcd[11:8] == 4'd0);
    lz[1]       = lz[2] && (disp_bcd[7:4] == 4'd0);
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    nib      = disp_bcd[{idx, 2'b00} +: 4];
    code_nxt = (nib > 4'd9) ? CODE_ERR : nib;
    if ((idx == 2'd3) && disp_neg) code_nxt = CODE_MINUS;
    anode_nxt = (blank || lz[idx]) ? ANODE_OFF : anode_for(idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      pending     <= 1'b0;
      pend_bcd    <= '0;
      pend_neg    <= 1'b0;
      disp_bcd    <= '0;
      disp_neg    <= 1'b0;
      digit_code  <= '0;
      anode       <= ANODE_OFF;
      frame_start <= 1'b0;
      shown       <= 1'b0;
      shown_idx   <= '0;
    end else begin
      if (tick) idx <= idx + 2'd1;

      if (commit) begin
        disp_bcd <= pend_bcd;
        disp_neg <= pend_neg;
        pending  <= 1'b0;
      end else if (load_valid && load_ready) begin
        pend_bcd <= bcd_in;
        pend_neg <= neg_in;
        pending  <= 1'b1;
      end

      // Pulse on entry to digit 0, including the very first update after reset.
      digit_code  <= code_nxt;
      anode       <= anode_nxt;
      frame_start <= (idx == 2'd0) && (!shown || (shown_idx != 2'd0));
      shown       <= 1'b1;
      shown_idx   <= idx;
    end
  end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range is 2 or more.
REQ-002 clk  input  1  sole clock; one clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 bcd_in  input  16  four BCD nibbles; [3:0] is digit 0 (rightmost) and [15:12] is digit 3.
REQ-005 neg_in  input  1  value is negative; a minus sign is shown.
REQ-006 load_valid  input  1  offers bcd_in/neg_in for display.
REQ-007 load_ready  output  1  pending buffer is empty; a load is accepted.
REQ-008 blank  input  1  when high, all anodes are off.
REQ-009 digit_code  output  4  code sent to the downstream 7-segment decoder: 0-9 digit, 10 minus, 15 error.
REQ-010 anode  output  4  active-low digit enables; bit n drives digit n.
REQ-011 frame_start  output  1  one-cycle pulse when digit 0 becomes active.

Function
REQ-012 A prescaler counts 0..REFRESH_DIV-1 and wraps; a tick is asserted in the cycle the count equals REFRESH_DIV-1.
REQ-013 On a tick, the digit index advances modulo 4 in the order 0,1,2,3,0.
REQ-014 A load handshake completes on load_valid && load_ready; bcd_in/neg_in are captured into the pending buffer and the pending flag is set.
REQ-015 load_ready = !pending flag (combinational); a load offered while load_ready is low is ignored and is not queued.
REQ-016 Commit: on a tick with index 3 (frame wrap), if the pending flag is set, the display register takes the pending value and the pending flag clears in the same edge.
REQ-017 The display register changes only at commit; no frame ever mixes old and new digits.
REQ-018 In a commit cycle load_ready is still low; a new load becomes possible from the following cycle.
REQ-019 digit_code, anode and frame_start are registered; they reflect the new index one cycle after the index changes.
REQ-020 Exactly one anode bit is low at a time unless the active digit is blanked or blank=1, in which case anode=4'b1111.
REQ-021 Nibbles 10-15 in an unblanked position give digit_code=15 (error indicator).
REQ-022 When neg_in is set in the display register, digit 3 shows code 10 and bcd nibble 3 is ignored.
REQ-023 frame_start pulses for one cycle each time the registered outputs select digit 0.
REQ-024 Changes to blank take effect on the next registered output update, with no prescaler restart.

Reset
REQ-025 While rst is high at an edge:
- prescaler=0, index=0
- display register=0 and neg=0
- pending flag=0
- anode=4'b1111, digit_code=0, frame_start=0
REQ-026 In the first cycle after rst deasserts, load_ready=1.
REQ-027 Reset mid-operation discards any pending load, and the display returns to 0.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN controls leading-zero blanking.
REQ-029 With LEADING_ZERO_BLANK_EN defined:
- zero nibbles left of the most significant non-zero digit are blanked (anode off) in positions 3..1
- digit 0 is never blanked
- when negative, the minus sign stays at digit 3 and blanking applies only to positions 2..1
REQ-030 Without LEADING_ZERO_BLANK_EN, all four positions are always driven.

Structure
REQ-031 Shared package display_pkg holds:
- N_DIGITS=4
- CODE_MINUS=4'd10
- CODE_ERR=4'd15
- ANODE_OFF=4'b1111
- the digit-code typedef (4-bit)
REQ-032 Sub-module refresh_prescaler (counter plus tick output, parameter REFRESH_DIV) is instantiated once; all other logic is in display_scanner.

Verification (bench uses REFRESH_DIV=4)
REQ-033 Reset then idle -> anode=4'b1111 for 1 cycle, load_ready=1; then the digit 0 anode is low with digit_code=0, and frame_start pulses every 16 cycles.
REQ-034 Load 16'h1234 with neg=0 -> after the next frame wrap, successive slots show codes 4,3,2,1 with anodes 1110,1101,1011,0111, each held for 4 cycles.
REQ-035 Load 16'h0042, then a second load 2 cycles later -> second load refused (load_ready=0); with LEADING_ZERO_BLANK_EN, digits 3 and 2 have anode 1111 and digit 0 shows 2.
REQ-036 Load 16'h0007 with neg=1 -> digit 3 shows code 10; with the macro, digits 2..1 are blanked; without it, they show 0.
REQ-037 Load 16'h00A5 -> digit 1 shows code 15; blank=1 mid-frame -> anode=1111 from the next output update.
REQ-038 Assert rst while a load is pending -> pending is dropped, the display shows 0000, and load_ready=1 after release.
